// File: rtl/sdram_loader_if.sv
// Wishbone read port and 16-bit pixel stream of the SDRAM loader.
// master = loader side, slave = memory / consumer side.
interface sdram_loader_if;
    logic        stb_o;
    logic        cyc_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [31:0] addr_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        stall_i;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;

    modport master (
        output stb_o, cyc_o, we_o, sel_o, addr_o,
        output pix_data, pix_valid, pix_last,
        input  dat_i, ack_i, stall_i, pix_ready
    );

    modport slave (
        input  stb_o, cyc_o, we_o, sel_o, addr_o,
        input  pix_data, pix_valid, pix_last,
        output dat_i, ack_i, stall_i, pix_ready
    );
endinterface

// File: rtl/sdram_loader.sv
// Reads NUM_WORDS words from SDRAM over Wishbone into a FWFT FIFO feeding a pixel stream.
// Optional WAIT_ACK watchdog with sticky err: define LOADER_TIMEOUT_EN.
module sdram_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'd0,
    parameter int          NUM_WORDS  = 118,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic           CLKOUT,
    input  logic           rst_n,
    input  logic           start,
    sdram_loader_if.master bus,
    output logic           busy,
    output logic           done,
    output logic           err
);
    localparam int             AW    = $clog2(FIFO_DEPTH);
    localparam logic [15:0]    NW    = 16'(NUM_WORDS);
    localparam logic [15:0]    NW_M1 = 16'(NUM_WORDS - 1);
    localparam logic [AW:0]    DEPTH = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_CHECK, S_DRAIN, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    start_q;
    logic [15:0]   idx_q, idx_d;
    logic [15:0]   pop_q;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          done_q, done_d;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic          start_edge, push, pop, clr;
    logic          dat_unused;

`ifdef LOADER_TIMEOUT_EN
    logic [7:0]    wd_q, wd_d;
    logic          err_q, err_d;
`endif

    assign start_edge = start_q[0] & ~start_q[1];
    assign pop        = (cnt_q != '0) & bus.pix_ready;
    assign dat_unused = ^bus.dat_i[31:16];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = done_q;
        push    = 1'b0;
        clr     = 1'b0;
`ifdef LOADER_TIMEOUT_EN
        wd_d    = 8'd0;
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    state_d = S_REQ;
                    idx_d   = 16'd0;
                    done_d  = 1'b0;
                    clr     = 1'b1;
`ifdef LOADER_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_REQ: begin
                if (!bus.stall_i) begin
                    if (bus.ack_i) begin
                        push    = 1'b1;
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.ack_i) begin
                    push    = 1'b1;
                    state_d = S_CHECK;
                end
`ifdef LOADER_TIMEOUT_EN
                else if (wd_q == 8'hFF) begin
                    state_d = S_REQ;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`endif
            end
            S_CHECK: begin
                if (idx_q == NW)
                    state_d = S_DRAIN;
                else if (cnt_q < DEPTH)
                    state_d = S_REQ;
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (push)
            idx_d = idx_q + 16'd1;
    end

    always_ff @(posedge CLKOUT or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            start_q <= 2'b00;
            idx_q   <= 16'd0;
            pop_q   <= 16'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= {start_q[0], start};
            idx_q   <= idx_d;
            done_q  <= done_d;
            if (clr)
                pop_q <= 16'd0;
            else if (pop)
                pop_q <= pop_q + 16'd1;
            if (push)
                wptr_q <= wptr_q + 1'b1;
            if (pop)
                rptr_q <= rptr_q + 1'b1;
            if (push && !pop)
                cnt_q <= cnt_q + 1'b1;
            else if (!push && pop)
                cnt_q <= cnt_q - 1'b1;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    always_ff @(posedge CLKOUT or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= 8'd0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Storage needs no reset: pix_data is masked while the FIFO is empty.
    always_ff @(posedge CLKOUT) begin
        if (push)
            mem_q[wptr_q] <= bus.dat_i[15:0];
    end

    assign bus.cyc_o     = (state_q == S_REQ) | (state_q == S_WAIT);
    assign bus.stb_o     = (state_q == S_REQ);
    assign bus.we_o      = 1'b0;
    assign bus.sel_o     = bus.cyc_o ? 4'b0011 : 4'b0000;
    assign bus.addr_o    = BASE_ADDR + {16'd0, idx_q};
    assign bus.pix_valid = (cnt_q != '0);
    assign bus.pix_data  = bus.pix_valid ? mem_q[rptr_q] : 16'd0;
    assign bus.pix_last  = bus.pix_valid & (pop_q == NW_M1);
    assign busy          = (state_q != S_IDLE) & (state_q != S_DONE);
    assign done          = done_q;
endmodule

// File: tb/tb_sdram_loader.sv
// Scoreboard bench for sdram_loader: Wishbone memory model, stream monitor, directed loads.
// Base address sits just below 2^32 so the address wrap is exercised.
module tb_sdram_loader;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;
    localparam int          NW   = 20;
    localparam int          FD   = 8;

    logic CLKOUT = 1'b0;
    logic rst_n  = 1'b0;
    logic start  = 1'b0;
    logic busy, done, err;

    sdram_loader_if bus();

    sdram_loader #(
        .BASE_ADDR (BASE),
        .NUM_WORDS (NW),
        .FIFO_DEPTH(FD)
    ) dut (
        .CLKOUT(CLKOUT),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 CLKOUT = ~CLKOUT;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t exp_q[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          n_ack = 0;
    int          n_hold_acc = 0;
    int          stall_left = 0;
    int          hold = 0;
    logic        pending = 1'b0;
    logic        first_seen = 1'b0;
    logic        hold_arm = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic [31:0] first_addr = 32'd0;
    logic [31:0] hold_addr = 32'h0000_1234;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLKOUT);
        #1;
    endtask

    task automatic load_exp();
        logic [15:0] b16;
        b16 = BASE[15:0];
        for (int i = 0; i < NW; i++)
            exp_q.push_back({16'(16'h1000 + b16 + 16'(i)), i == NW - 1});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(3);
        start = 1'b0;
        tick(1);
    endtask

    task automatic wait_done(input string nm, input int lim);
        for (int k = 0; k < lim; k++) begin
            if (done) break;
            tick(1);
        end
        check(nm, done, 1);
    endtask

    // Memory: optional stall on strobe, ack one cycle after accept (or held).
    initial begin
        bus.ack_i   = 1'b0;
        bus.stall_i = 1'b0;
        bus.dat_i   = 32'd0;
        forever begin
            @(negedge CLKOUT);
            bus.ack_i = 1'b0;
            if (pending) begin
                if (hold > 0) begin
                    hold--;
                end else begin
                    bus.ack_i = 1'b1;
                    bus.dat_i = {16'hDEAD, 16'(16'h1000 + paddr[15:0])};
                    pending   = 1'b0;
                    n_ack++;
                end
            end
            bus.stall_i = bus.stb_o && (stall_left > 0);
            if (bus.stall_i)
                stall_left--;
            if (bus.stb_o && !bus.stall_i) begin
                n_acc++;
                pending = 1'b1;
                paddr   = bus.addr_o;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_addr = bus.addr_o;
                end
                if (bus.addr_o == hold_addr) begin
                    n_hold_acc++;
                    if (hold_arm) begin
                        hold     = 300;
                        hold_arm = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge CLKOUT);
            if (rst_n && bus.pix_valid && bus.pix_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_word: got %h expected none", bus.pix_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_data", bus.pix_data, e.d);
                    check("pix_last", bus.pix_last, e.l);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.pix_ready = 1'b0;
        tick(3);
        check("rst_stb", bus.stb_o, 0);
        check("rst_cyc", bus.cyc_o, 0);
        check("rst_we", bus.we_o, 0);
        check("rst_sel", bus.sel_o, 0);
        check("rst_addr", bus.addr_o, BASE);
        check("rst_data", bus.pix_data, 0);
        check("rst_valid", bus.pix_valid, 0);
        check("rst_last", bus.pix_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick(2);

        // Full load with 5-cycle stall on the first request.
        bus.pix_ready = 1'b1;
        n_acc = 0;
        first_seen = 1'b0;
        stall_left = 5;
        load_exp();
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (bus.stb_o) break;
            tick(1);
        end
        check("stb_rise", bus.stb_o, 1);
        check("busy_with_stb", busy, 1);
        check("sel_active", bus.sel_o, 4'b0011);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("stall_stb", bus.stb_o, 1);
            check("stall_addr", bus.addr_o, BASE);
        end
        start = 1'b0;
        wait_done("basic_done", 500);
        check("basic_busy", busy, 0);
        check("basic_strobes", n_acc, NW);
        check("basic_first_addr", first_addr, BASE);
        check("basic_queue_empty", exp_q.size(), 0);

        // Backpressure: FIFO fills, loader parks with no strobe.
        bus.pix_ready = 1'b0;
        n_acc = 0;
        load_exp();
        pulse_start();
        check("restart_done_clr", done, 0);
        tick(80);
        check("bp_strobes", n_acc, FD);
        check("bp_stb", bus.stb_o, 0);
        check("bp_cyc", bus.cyc_o, 0);
        check("bp_addr", bus.addr_o, BASE + 32'd8);
        check("bp_valid", bus.pix_valid, 1);
        check("bp_busy", busy, 1);
        pulse_start();
        tick(5);
        check("ignore_strobes", n_acc, FD);
        check("ignore_busy", busy, 1);
        bus.pix_ready = 1'b1;
        wait_done("bp_done", 500);
        check("bp_all_strobes", n_acc, NW);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset after three acks, then reload from word 0.
        bus.pix_ready = 1'b0;
        n_ack = 0;
        pulse_start();
        for (int k = 0; k < 100; k++) begin
            if (n_ack >= 3) break;
            tick(1);
        end
        check("acks_before_reset", n_ack, 3);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_stb", bus.stb_o, 0);
        check("mid_rst_cyc", bus.cyc_o, 0);
        check("mid_rst_sel", bus.sel_o, 0);
        check("mid_rst_addr", bus.addr_o, BASE);
        check("mid_rst_valid", bus.pix_valid, 0);
        check("mid_rst_data", bus.pix_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        n_acc = 0;
        first_seen = 1'b0;
        bus.pix_ready = 1'b1;
        load_exp();
        pulse_start();
        wait_done("reload_done", 500);
        check("reload_first_addr", first_addr, BASE);
        check("reload_strobes", n_acc, NW);
        check("reload_queue_empty", exp_q.size(), 0);

`ifdef LOADER_TIMEOUT_EN
        // Word 2 ack withheld: watchdog re-requests same address.
        n_acc = 0;
        n_hold_acc = 0;
        hold_addr = BASE + 32'd2;
        hold_arm = 1'b1;
        load_exp();
        pulse_start();
        for (int k = 0; k < 400; k++) begin
            if (err) break;
            tick(1);
        end
        check("to_err_set", err, 1);
        check("to_restb", bus.stb_o, 1);
        check("to_readdr", bus.addr_o, BASE + 32'd2);
        wait_done("to_done", 2000);
        check("to_hold_reqs", n_hold_acc, 2);
        check("to_strobes", n_acc, NW + 1);
        check("to_err_sticky", err, 1);
        check("to_queue_empty", exp_q.size(), 0);
        load_exp();
        pulse_start();
        check("to_err_clr", err, 0);
        wait_done("to_clean_done", 500);
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
